// File: rtl/ddr3_sched_pkg.sv
// Shared definitions for the DDR3 command scheduler: FSM states, command
// encodings, address field positions and DDR3 command pin encodings.
package ddr3_sched_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ACT,
        ST_WAIT_RCD,
        ST_RW,
        ST_WAIT_DONE,
        ST_REF,
        ST_WAIT_RFC
    } state_t;

    // Command field of the CMD FIFO word
    localparam logic [2:0] CMD_READ  = 3'b001;
    localparam logic [2:0] CMD_WRITE = 3'b010;

    // CMD FIFO word layout: {cmd[2:0], sz[1:0], op[2:0], addr[25:0]}
    localparam int CMD_MSB  = 33;
    localparam int CMD_LSB  = 31;
    localparam int ADDR_MSB = 25;

    // Address decode: row / bank / column
    localparam int ROW_MSB = 25;
    localparam int ROW_LSB = 13;
    localparam int BA_MSB  = 12;
    localparam int BA_LSB  = 10;
    localparam int COL_MSB = 9;
    localparam int COL_LSB = 0;

    // DDR3 command pins, active low
    typedef struct packed {
        logic csbar;
        logic rasbar;
        logic casbar;
        logic webar;
    } pins_t;

    localparam pins_t PINS_NOP = 4'b0111;
    localparam pins_t PINS_ACT = 4'b0011;
    localparam pins_t PINS_RD  = 4'b0101;
    localparam pins_t PINS_WR  = 4'b0100;
    localparam pins_t PINS_REF = 4'b0001;

    // Largest of three timing values, used to size the shared wait counter
    function automatic int max3(input int x, input int y, input int z);
        int m;
        m = (x > y) ? x : y;
        return (m > z) ? m : z;
    endfunction

endpackage

// File: rtl/ddr3_cmd_scheduler_refresh_timer.sv
// Refresh interval timer for the DDR3 command scheduler (module
// ddr3_refresh_timer). Counts 0..T_REFI-1 while the memory is ready, raises
// a pending request on every wrap and flags a sticky overrun when a wrap
// arrives before the previous request was serviced. Only instantiated when
// DDR3_SCHED_REFRESH_EN is defined.
module ddr3_refresh_timer #(
    parameter int T_REFI = 2400
) (
    input  logic clk,
    input  logic resetbar,
    input  logic ready,
    input  logic ref_issue,
    output logic ref_pending,
    output logic ref_overrun
);

    localparam int CW = (T_REFI > 2) ? $clog2(T_REFI) : 1;
    localparam logic [CW-1:0] LAST = CW'(T_REFI - 1);

    logic [CW-1:0] ref_count;
    logic          wrap;

    assign wrap = ready && (ref_count == LAST);

    // Interval counter, advancing only while the init engine reports ready
    always_ff @(posedge clk) begin
        if (!resetbar) begin
            ref_count <= '0;
        end else if (ready) begin
            ref_count <= wrap ? '0 : ref_count + CW'(1);
        end
    end

    // Pending request: a wrap wins over the clear so a coincident wrap is kept
    always_ff @(posedge clk) begin
        if (!resetbar) begin
            ref_pending <= 1'b0;
        end else if (wrap) begin
            ref_pending <= 1'b1;
        end else if (ref_issue) begin
            ref_pending <= 1'b0;
        end
    end

    // Sticky overrun: a new interval expired while the last one was still unserviced
    always_ff @(posedge clk) begin
        if (!resetbar) begin
            ref_overrun <= 1'b0;
        end else if (wrap && ref_pending && !ref_issue) begin
            ref_overrun <= 1'b1;
        end
    end

endmodule

// File: rtl/ddr3_cmd_scheduler.sv
// DDR3 command scheduler: pops READ/WRITE requests from a first-word-fall-
// through CMD FIFO and sequences ACT -> RD/WR with auto-precharge, waiting
// out tRCD and the post-access recovery. Optional periodic refresh with
// priority over commands is built in when DDR3_SCHED_REFRESH_EN is defined.
module ddr3_cmd_scheduler
    import ddr3_sched_pkg::*;
#(
    parameter int T_RCD  = 6,
    parameter int T_DONE = 14,
    parameter int T_RFC  = 64,
    parameter int T_REFI = 2400
) (
    input  logic        clk,
    input  logic        resetbar,
    input  logic        ready,
    input  logic        cmd_empty_bar,
    input  logic [33:0] cmd_data,
    output logic        cmd_get,
    input  logic        ret_full_bar,
    output logic        csbar,
    output logic        rasbar,
    output logic        casbar,
    output logic        webar,
    output logic [2:0]  ba,
    output logic [12:0] a,
    output logic        rd_issue,
    output logic        wr_issue,
    output logic [25:0] rw_addr,
    output logic        busy,
    output logic        ref_overrun
);

    localparam int MAX_WAIT = max3(T_RCD, T_DONE, T_RFC);
    localparam int CNT_W    = $clog2(MAX_WAIT + 1);

    state_t             state_q;
    state_t             state_d;
    logic [CNT_W-1:0]   wait_cnt;
    logic               wait_done;
    logic               is_write_q;
    logic [ADDR_MSB:0]  addr_q;
    logic [2:0]         head_cmd;
    logic               head_is_read;
    logic               head_is_write;
    logic               ref_pending;
    logic               pop;
    pins_t              pins;

    // Size and op fields are carried by the FIFO but have no effect here
    logic unused_fields;
    assign unused_fields = ^cmd_data[30:26];

    assign head_cmd      = cmd_data[CMD_MSB:CMD_LSB];
    assign head_is_read  = (head_cmd == CMD_READ);
    assign head_is_write = (head_cmd == CMD_WRITE);
    assign wait_done     = (wait_cnt == '0);

    // A READ may only leave the FIFO when its data has somewhere to go;
    // anything else at the head (including junk commands) pops immediately.
    assign pop = (state_q == ST_IDLE) && resetbar && ready && !ref_pending &&
                 cmd_empty_bar && (!head_is_read || ret_full_bar);

`ifdef DDR3_SCHED_REFRESH_EN
    logic ref_issue;
    assign ref_issue = (state_q == ST_REF);

    ddr3_refresh_timer #(
        .T_REFI(T_REFI)
    ) u_refresh_timer (
        .clk        (clk),
        .resetbar   (resetbar),
        .ready      (ready),
        .ref_issue  (ref_issue),
        .ref_pending(ref_pending),
        .ref_overrun(ref_overrun)
    );
`else
    // Refresh disabled: the interval parameter is accepted but has no effect
    localparam int unused_refi = T_REFI;
    assign ref_pending = 1'b0;
    assign ref_overrun = 1'b0;
`endif

    // State register
    always_ff @(posedge clk) begin
        if (!resetbar) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; refresh is checked before the FIFO head
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (ready && ref_pending) begin
                    state_d = ST_REF;
                end else if (pop && (head_is_read || head_is_write)) begin
                    state_d = ST_ACT;
                end
            end
            ST_ACT:       state_d = ST_WAIT_RCD;
            ST_WAIT_RCD:  if (wait_done) state_d = ST_RW;
            ST_RW:        state_d = ST_WAIT_DONE;
            ST_WAIT_DONE: if (wait_done) state_d = ST_IDLE;
            ST_REF:       state_d = ST_WAIT_RFC;
            ST_WAIT_RFC:  if (wait_done) state_d = ST_IDLE;
            default:      state_d = ST_IDLE;
        endcase
    end

    // Shared wait counter, loaded on entry to each wait state and run down to zero
    always_ff @(posedge clk) begin
        if (!resetbar) begin
            wait_cnt <= '0;
        end else if (state_d != state_q) begin
            case (state_d)
                ST_WAIT_RCD:  wait_cnt <= CNT_W'(T_RCD - 2);
                ST_WAIT_DONE: wait_cnt <= CNT_W'(T_DONE - 1);
                ST_WAIT_RFC:  wait_cnt <= CNT_W'(T_RFC - 2);
                default:      wait_cnt <= '0;
            endcase
        end else if (!wait_done) begin
            wait_cnt <= wait_cnt - CNT_W'(1);
        end
    end

    // Capture the popped request; the FIFO head moves on after the pop
    always_ff @(posedge clk) begin
        if (!resetbar) begin
            is_write_q <= 1'b0;
            addr_q     <= '0;
        end else if (pop && (head_is_read || head_is_write)) begin
            is_write_q <= head_is_write;
            addr_q     <= cmd_data[ADDR_MSB:0];
        end
    end

    // Output decode: NOP everywhere except the single ACT, RD/WR and REF cycles
    always_comb begin
        pins     = PINS_NOP;
        ba       = '0;
        a        = '0;
        rd_issue = 1'b0;
        wr_issue = 1'b0;
        rw_addr  = '0;
        cmd_get  = pop;
        busy     = (state_q != ST_IDLE);
        case (state_q)
            ST_ACT: begin
                pins = PINS_ACT;
                ba   = addr_q[BA_MSB:BA_LSB];
                a    = addr_q[ROW_MSB:ROW_LSB];
            end
            ST_RW: begin
                pins     = is_write_q ? PINS_WR : PINS_RD;
                ba       = addr_q[BA_MSB:BA_LSB];
                a        = {2'b00, 1'b1, addr_q[COL_MSB:COL_LSB]};
                rd_issue = !is_write_q;
                wr_issue = is_write_q;
                rw_addr  = addr_q;
            end
            ST_REF: begin
                pins = PINS_REF;
            end
            default: begin
                pins = PINS_NOP;
            end
        endcase
    end

    assign csbar  = pins.csbar;
    assign rasbar = pins.rasbar;
    assign casbar = pins.casbar;
    assign webar  = pins.webar;

endmodule

// File: tb/tb_ddr3_cmd_scheduler.sv
// Directed testbench for ddr3_cmd_scheduler. Refresh scenarios are compiled
// in when DDR3_SCHED_REFRESH_EN is defined; otherwise the bench confirms
// refresh never appears.
module tb_ddr3_cmd_scheduler;

    localparam logic [3:0] P_NOP = 4'b0111;
    localparam logic [3:0] P_ACT = 4'b0011;
    localparam logic [3:0] P_RD  = 4'b0101;
    localparam logic [3:0] P_WR  = 4'b0100;
    localparam logic [3:0] P_REF = 4'b0001;

    logic        clk = 1'b0;
    logic        resetbar = 1'b0;
    logic        ready = 1'b0;
    logic        cmd_empty_bar = 1'b0;
    logic [33:0] cmd_data = '0;
    logic        ret_full_bar = 1'b1;
    logic        cmd_get, csbar, rasbar, casbar, webar;
    logic [2:0]  ba;
    logic [12:0] a;
    logic        rd_issue, wr_issue, busy, ref_overrun;
    logic [25:0] rw_addr;
    logic [3:0]  pin_cmd;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    assign pin_cmd = {csbar, rasbar, casbar, webar};

    ddr3_cmd_scheduler dut (
        .clk          (clk),
        .resetbar     (resetbar),
        .ready        (ready),
        .cmd_empty_bar(cmd_empty_bar),
        .cmd_data     (cmd_data),
        .cmd_get      (cmd_get),
        .ret_full_bar (ret_full_bar),
        .csbar        (csbar),
        .rasbar       (rasbar),
        .casbar       (casbar),
        .webar        (webar),
        .ba           (ba),
        .a            (a),
        .rd_issue     (rd_issue),
        .wr_issue     (wr_issue),
        .rw_addr      (rw_addr),
        .busy         (busy),
        .ref_overrun  (ref_overrun)
    );

`ifdef DDR3_SCHED_REFRESH_EN
    logic        o_cmd_get, o_csbar, o_rasbar, o_casbar, o_webar;
    logic [2:0]  o_ba;
    logic [12:0] o_a;
    logic        o_rd_issue, o_wr_issue, o_busy, o_ref_overrun;
    logic [25:0] o_rw_addr;

    ddr3_cmd_scheduler #(.T_REFI(10)) dut_ovr (
        .clk          (clk),
        .resetbar     (resetbar),
        .ready        (ready),
        .cmd_empty_bar(cmd_empty_bar),
        .cmd_data     (cmd_data),
        .cmd_get      (o_cmd_get),
        .ret_full_bar (ret_full_bar),
        .csbar        (o_csbar),
        .rasbar       (o_rasbar),
        .casbar       (o_casbar),
        .webar        (o_webar),
        .ba           (o_ba),
        .a            (o_a),
        .rd_issue     (o_rd_issue),
        .wr_issue     (o_wr_issue),
        .rw_addr      (o_rw_addr),
        .busy         (o_busy),
        .ref_overrun  (o_ref_overrun)
    );
`endif

    // Move to 1 ns after the n-th next rising edge; inputs are driven here
    task automatic goto_next(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Synchronous reset with idle inputs; returns in the first cycle out of reset
    task automatic do_reset();
        resetbar      = 1'b0;
        ready         = 1'b1;
        cmd_empty_bar = 1'b0;
        ret_full_bar  = 1'b1;
        cmd_data      = '0;
        repeat (2) @(posedge clk);
        #1;
        resetbar = 1'b1;
    endtask

    // Bounded wait for the scheduler to return to IDLE
    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        @(negedge clk);
        while (busy !== 1'b0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL %s_idle_timeout: busy=%b after %0d cycles, expected 0", tag, busy, n);
        end
    endtask

    task automatic test_reset();
        resetbar      = 1'b0;
        ready         = 1'b1;
        cmd_empty_bar = 1'b1;
        ret_full_bar  = 1'b1;
        cmd_data      = {3'b010, 2'b00, 3'b000, 26'h2A_C1F5};
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b expected 0", busy); end
        checks++;
        if (cmd_get !== 1'b0) begin errors++; $display("FAIL rst_cmd_get: got %b expected 0", cmd_get); end
        checks++;
        if (pin_cmd !== P_NOP || ba !== 3'd0 || a !== 13'd0) begin
            errors++; $display("FAIL rst_pins: got pins=%b ba=%h a=%h expected 0111/0/0", pin_cmd, ba, a);
        end
        checks++;
        if (rd_issue !== 1'b0 || wr_issue !== 1'b0 || rw_addr !== 26'd0) begin
            errors++; $display("FAIL rst_issue: got rd=%b wr=%b rw_addr=%h expected 0/0/0", rd_issue, wr_issue, rw_addr);
        end
        checks++;
        if (ref_overrun !== 1'b0) begin errors++; $display("FAIL rst_overrun: got %b expected 0", ref_overrun); end
        goto_next(1);
        cmd_empty_bar = 1'b0;
        resetbar      = 1'b1;
    endtask

    task automatic test_write();
        goto_next(1);
        cmd_empty_bar = 1'b1;
        cmd_data      = {3'b010, 2'b00, 3'b000, 26'h2A_C1F5};
        @(negedge clk);
        checks++;
        if (cmd_get !== 1'b1) begin errors++; $display("FAIL wr_pop: cmd_get=%b expected 1", cmd_get); end
        goto_next(1);
        cmd_empty_bar = 1'b0;
        cmd_data      = '0;
        @(negedge clk);
        checks++;
        if (pin_cmd !== P_ACT || ba !== 3'b000 || a !== 13'h0156) begin
            errors++; $display("FAIL wr_act: got pins=%b ba=%h a=%h expected 0011/0/0156", pin_cmd, ba, a);
        end
        goto_next(1);
        ready = 1'b0;
        @(negedge clk);
        checks++;
        if (pin_cmd !== P_NOP || busy !== 1'b1) begin
            errors++; $display("FAIL wr_wait_rcd: got pins=%b busy=%b expected 0111/1", pin_cmd, busy);
        end
        goto_next(5);
        @(negedge clk);
        checks++;
        if (pin_cmd !== P_WR || ba !== 3'b000 || a !== 13'h05F5) begin
            errors++; $display("FAIL wr_cmd: got pins=%b ba=%h a=%h expected 0100/0/05F5", pin_cmd, ba, a);
        end
        checks++;
        if (wr_issue !== 1'b1 || rd_issue !== 1'b0 || rw_addr !== 26'h2A_C1F5) begin
            errors++; $display("FAIL wr_issue: got wr=%b rd=%b rw_addr=%h expected 1/0/2AC1F5", wr_issue, rd_issue, rw_addr);
        end
        goto_next(1);
        @(negedge clk);
        checks++;
        if (wr_issue !== 1'b0 || pin_cmd !== P_NOP) begin
            errors++; $display("FAIL wr_issue_pulse: got wr=%b pins=%b expected 0/0111", wr_issue, pin_cmd);
        end
        goto_next(13);
        @(negedge clk);
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL wr_busy_n21: got %b expected 1", busy); end
        goto_next(1);
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL wr_idle_n22: got busy=%b expected 0", busy); end
        ready = 1'b1;
    endtask

    task automatic test_read_stall();
        goto_next(1);
        cmd_empty_bar = 1'b1;
        ret_full_bar  = 1'b0;
        cmd_data      = {3'b001, 2'b00, 3'b000, 13'h1ABC, 3'd5, 10'h2C3};
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checks++;
            if (cmd_get !== 1'b0) begin errors++; $display("FAIL rd_stall_pop[%0d]: cmd_get=%b expected 0", i, cmd_get); end
            checks++;
            if (pin_cmd !== P_NOP || busy !== 1'b0) begin
                errors++; $display("FAIL rd_stall_pins[%0d]: got pins=%b busy=%b expected 0111/0", i, pin_cmd, busy);
            end
            goto_next(1);
        end
        ret_full_bar = 1'b1;
        @(negedge clk);
        checks++;
        if (cmd_get !== 1'b1) begin errors++; $display("FAIL rd_pop: cmd_get=%b expected 1", cmd_get); end
        goto_next(1);
        cmd_empty_bar = 1'b0;
        @(negedge clk);
        checks++;
        if (pin_cmd !== P_ACT || ba !== 3'd5 || a !== 13'h1ABC) begin
            errors++; $display("FAIL rd_act: got pins=%b ba=%h a=%h expected 0011/5/1ABC", pin_cmd, ba, a);
        end
        goto_next(6);
        @(negedge clk);
        checks++;
        if (pin_cmd !== P_RD || ba !== 3'd5 || a !== 13'h06C3) begin
            errors++; $display("FAIL rd_cmd: got pins=%b ba=%h a=%h expected 0101/5/06C3", pin_cmd, ba, a);
        end
        checks++;
        if (rd_issue !== 1'b1 || wr_issue !== 1'b0 || rw_addr !== {13'h1ABC, 3'd5, 10'h2C3}) begin
            errors++; $display("FAIL rd_issue: got rd=%b wr=%b rw_addr=%h expected 1/0/35796C3", rd_issue, wr_issue, rw_addr);
        end
        goto_next(15);
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL rd_idle_n22: got busy=%b expected 0", busy); end
    endtask

    task automatic test_discard();
        goto_next(1);
        cmd_empty_bar = 1'b1;
        cmd_data      = {3'b111, 2'b00, 3'b000, 26'h3FF_FFFF};
        @(negedge clk);
        checks++;
        if (cmd_get !== 1'b1) begin errors++; $display("FAIL disc_pop: cmd_get=%b expected 1", cmd_get); end
        goto_next(1);
        cmd_data = {3'b010, 2'b00, 3'b000, 13'h0F0F, 3'd2, 10'h155};
        @(negedge clk);
        checks++;
        if (cmd_get !== 1'b1 || pin_cmd !== P_NOP || busy !== 1'b0) begin
            errors++; $display("FAIL disc_next_pop: got cmd_get=%b pins=%b busy=%b expected 1/0111/0", cmd_get, pin_cmd, busy);
        end
        goto_next(1);
        cmd_empty_bar = 1'b0;
        @(negedge clk);
        checks++;
        if (pin_cmd !== P_ACT || ba !== 3'd2 || a !== 13'h0F0F) begin
            errors++; $display("FAIL disc_act: got pins=%b ba=%h a=%h expected 0011/2/0F0F", pin_cmd, ba, a);
        end
        goto_next(21);
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL disc_idle: got busy=%b expected 0", busy); end
    endtask

    task automatic test_mid_reset();
        int act_seen;
        goto_next(1);
        cmd_empty_bar = 1'b1;
        cmd_data      = {3'b010, 2'b00, 3'b000, 13'h0777, 3'd6, 10'h0AA};
        @(negedge clk);
        checks++;
        if (cmd_get !== 1'b1) begin errors++; $display("FAIL mrst_pop: cmd_get=%b expected 1", cmd_get); end
        goto_next(1);
        cmd_empty_bar = 1'b0;
        goto_next(2);
        resetbar = 1'b0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL mrst_in_rcd: got busy=%b expected 1", busy); end
        goto_next(1);
        resetbar = 1'b1;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || pin_cmd !== P_NOP || cmd_get !== 1'b0 || ba !== 3'd0 || a !== 13'd0) begin
            errors++; $display("FAIL mrst_after: got busy=%b pins=%b cmd_get=%b ba=%h a=%h expected 0/0111/0/0/0", busy, pin_cmd, cmd_get, ba, a);
        end
        act_seen = 0;
        for (int i = 0; i < 10; i++) begin
            goto_next(1);
            @(negedge clk);
            if (pin_cmd !== P_NOP || wr_issue !== 1'b0) act_seen++;
        end
        checks++;
        if (act_seen !== 0) begin errors++; $display("FAIL mrst_no_activity: got %0d active cycles expected 0", act_seen); end
        goto_next(1);
        cmd_empty_bar = 1'b1;
        @(negedge clk);
        checks++;
        if (cmd_get !== 1'b1) begin errors++; $display("FAIL mrst_fresh_pop: cmd_get=%b expected 1", cmd_get); end
        goto_next(1);
        cmd_empty_bar = 1'b0;
        @(negedge clk);
        checks++;
        if (pin_cmd !== P_ACT || ba !== 3'd6 || a !== 13'h0777) begin
            errors++; $display("FAIL mrst_act: got pins=%b ba=%h a=%h expected 0011/6/0777", pin_cmd, ba, a);
        end
        wait_idle("mrst");
    endtask

`ifdef DDR3_SCHED_REFRESH_EN
    task automatic test_refresh();
        int off;
        int found;
        int gets;
        do_reset();
        off   = 0;
        found = 0;
        goto_next(1);
        off           = 1;
        cmd_empty_bar = 1'b1;
        cmd_data      = {3'b111, 31'd0};
        while (off < 3000) begin
            @(negedge clk);
            if (cmd_get === 1'b0) begin
                found = 1;
                break;
            end
            goto_next(1);
            off++;
        end
        checks++;
        if (found !== 1) begin errors++; $display("FAIL ref_found: got %0d expected 1", found); end
        checks++;
        if (off !== 2400) begin errors++; $display("FAIL ref_cycle: got offset %0d expected 2400", off); end
        goto_next(1);
        @(negedge clk);
        checks++;
        if (pin_cmd !== P_REF || busy !== 1'b1 || ba !== 3'd0 || a !== 13'd0) begin
            errors++; $display("FAIL ref_pins: got pins=%b busy=%b ba=%h a=%h expected 0001/1/0/0", pin_cmd, busy, ba, a);
        end
        gets = (cmd_get === 1'b0) ? 0 : 1;
        for (int j = 2; j <= 64; j++) begin
            goto_next(1);
            @(negedge clk);
            if (cmd_get !== 1'b0) gets++;
        end
        checks++;
        if (gets !== 0) begin errors++; $display("FAIL ref_no_pop: got %0d pops expected 0", gets); end
        goto_next(1);
        @(negedge clk);
        checks++;
        if (cmd_get !== 1'b1) begin errors++; $display("FAIL ref_pop_m65: cmd_get=%b expected 1", cmd_get); end
        cmd_empty_bar = 1'b0;
    endtask

    task automatic test_overrun();
        do_reset();
        @(negedge clk);
        checks++;
        if (o_ref_overrun !== 1'b0) begin errors++; $display("FAIL ovr_reset: got %b expected 0", o_ref_overrun); end
        goto_next(1);
        cmd_empty_bar = 1'b1;
        cmd_data      = {3'b010, 2'b00, 3'b000, 26'h012_3456};
        goto_next(18);
        @(negedge clk);
        checks++;
        if (o_ref_overrun !== 1'b0) begin errors++; $display("FAIL ovr_before: got %b expected 0", o_ref_overrun); end
        goto_next(1);
        @(negedge clk);
        checks++;
        if (o_ref_overrun !== 1'b1) begin errors++; $display("FAIL ovr_set: got %b expected 1", o_ref_overrun); end
        goto_next(20);
        cmd_empty_bar = 1'b0;
        @(negedge clk);
        checks++;
        if (o_ref_overrun !== 1'b1) begin errors++; $display("FAIL ovr_hold40: got %b expected 1", o_ref_overrun); end
        goto_next(20);
        @(negedge clk);
        checks++;
        if (o_ref_overrun !== 1'b1) begin errors++; $display("FAIL ovr_hold60: got %b expected 1", o_ref_overrun); end
        do_reset();
        @(negedge clk);
        checks++;
        if (o_ref_overrun !== 1'b0) begin errors++; $display("FAIL ovr_cleared: got %b expected 0", o_ref_overrun); end
    endtask
`else
    task automatic test_no_refresh();
        int bad;
        do_reset();
        goto_next(1);
        cmd_empty_bar = 1'b1;
        cmd_data      = {3'b111, 31'd0};
        bad = 0;
        for (int i = 0; i < 2600; i++) begin
            @(negedge clk);
            if (cmd_get !== 1'b1 || pin_cmd !== P_NOP || busy !== 1'b0) bad++;
            goto_next(1);
        end
        cmd_empty_bar = 1'b0;
        checks++;
        if (bad !== 0) begin errors++; $display("FAIL noref_stream: got %0d disturbed cycles expected 0", bad); end
        checks++;
        if (ref_overrun !== 1'b0) begin errors++; $display("FAIL noref_overrun: got %b expected 0", ref_overrun); end
    endtask
`endif

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        test_reset();
        test_write();
        test_read_stall();
        test_discard();
        test_mid_reset();
`ifdef DDR3_SCHED_REFRESH_EN
        test_refresh();
        test_overrun();
`else
        test_no_refresh();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
